// File: rtl/fpu_pkg.sv
// Shared FP64 field constants, collector FIFO entry layout and result classifier.
// FPU_RESULT_CLASSIFY_EN adds per-entry class flags to the entry layout.
package fpu_pkg;

  localparam int          SIGN_BIT   = 63;
  localparam int          EXP_MSB    = 62;
  localparam int          EXP_LSB    = 52;
  localparam int          MANT_W     = 52;
  localparam logic [10:0] EXP_ALL1   = 11'h7FF;
  localparam int          COLL_TAG_W = 4;

  typedef struct packed {
    logic is_zero;
    logic is_denorm;
    logic is_inf_nan;
  } fp_class_t;

  // The tag field width is fixed here; collectors use COLL_TAG_W as their tag width.
  typedef struct packed {
    logic [SIGN_BIT:0]     result;
    logic                  exception;
    logic [COLL_TAG_W-1:0] tag;
`ifdef FPU_RESULT_CLASSIFY_EN
    fp_class_t             cls;
`endif
  } coll_entry_t;

  function automatic fp_class_t fp_classify(input logic [SIGN_BIT:0] r);
    fp_class_t              c;
    logic [EXP_MSB-EXP_LSB:0] e;
    logic [MANT_W-1:0]      m;
    e = r[EXP_MSB:EXP_LSB];
    m = r[MANT_W-1:0];
    c.is_zero    = (e == '0) && (m == '0);
    c.is_denorm  = (e == '0) && (m != '0);
    c.is_inf_nan = (e == EXP_ALL1);
    return c;
  endfunction

endpackage

// File: rtl/fpu_result_fifo.sv
// Synchronous FIFO with async active-low reset; storage is cleared on reset so
// the head reads as zero until the first write.
module fpu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   LVL_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   LVL_FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;

  assign do_pop = pop & ~empty;
  assign full   = (level == LVL_FULL);
  assign empty  = (level == '0);
  assign rdata  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fpu_addsub_collector.sv
// Collects FP64 add/sub results: tracks tags through the adder's enable-gated
// pipe and buffers tagged results. FPU_RESULT_CLASSIFY_EN adds class-flag outputs.
module fpu_addsub_collector
  import fpu_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = COLL_TAG_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   issue_valid,
  input  logic [TAG_W-1:0]       issue_tag,
  output logic                   issue_ready,
  input  logic [63:0]            add_result,
  input  logic                   add_exception,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [63:0]            out_result,
  output logic                   out_exception,
  output logic [TAG_W-1:0]       out_tag,
`ifdef FPU_RESULT_CLASSIFY_EN
  output logic                   out_is_zero,
  output logic                   out_is_denorm,
  output logic                   out_is_inf_nan,
`endif
  output logic [$clog2(DEPTH):0] inflight
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]   SUM_DEPTH = (CNT_W+1)'(DEPTH);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high. issue_ready depends only on registered counts, enable and reset, never on
  // issue_valid or out_ready; out_valid is the registered FIFO-not-empty state.
  logic               accept;
  logic               push;
  logic               pop;
  logic [CNT_W-1:0]   level;
  logic [CNT_W:0]     committed;
  logic               fifo_full;
  logic               fifo_empty;
  logic [LATENCY-1:0] pipe_v;
  logic [TAG_W-1:0]   pipe_tag [LATENCY];
  coll_entry_t        wr_entry;
  coll_entry_t        rd_entry;

  // Every op already accepted owns a FIFO slot, so a push can never find it full.
  assign committed   = {1'b0, level} + {1'b0, inflight};
  assign issue_ready = rst_n & enable & (committed < SUM_DEPTH);
  assign accept      = issue_valid & issue_ready;
  assign push        = enable & pipe_v[LATENCY-1];
  assign out_valid   = ~fifo_empty;
  assign pop         = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_tag[i] <= '0;
    end else if (enable) begin
      pipe_v[0]   <= accept;
      pipe_tag[0] <= issue_tag;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({accept, push})
        2'b10:   inflight <= inflight + CNT_ONE;
        2'b01:   inflight <= inflight - CNT_ONE;
        default: inflight <= inflight;
      endcase
    end
  end

  always_comb begin
    wr_entry           = '0;
    wr_entry.result    = add_result;
    wr_entry.exception = add_exception;
    wr_entry.tag       = pipe_tag[LATENCY-1];
`ifdef FPU_RESULT_CLASSIFY_EN
    wr_entry.cls       = fp_classify(add_result);
`endif
  end

  fpu_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(coll_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push & ~fifo_full),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_result    = rd_entry.result;
  assign out_exception = rd_entry.exception;
  assign out_tag       = rd_entry.tag;
`ifdef FPU_RESULT_CLASSIFY_EN
  assign out_is_zero    = rd_entry.cls.is_zero;
  assign out_is_denorm  = rd_entry.cls.is_denorm;
  assign out_is_inf_nan = rd_entry.cls.is_inf_nan;
`endif

endmodule

// File: tb/tb_fpu_addsub_collector.sv
// Bench for fpu_addsub_collector: queue-based reference model of pending ops and
// buffered results, directed scenarios plus randomized traffic.
module tb_fpu_addsub_collector;

  localparam int LATENCY = 2;
  localparam int DEPTH   = 4;

  typedef struct {
    logic [3:0]  tag;
    logic [63:0] res;
    logic        exc;
    int          rem;
  } op_t;

  typedef struct {
    logic [3:0]  tag;
    logic [63:0] res;
    logic        exc;
    logic [2:0]  fl;
  } pop_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        enable = 1'b0;
  logic        issue_valid = 1'b0;
  logic [3:0]  issue_tag = '0;
  logic        issue_ready;
  logic [63:0] add_result = '0;
  logic        add_exception = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_result;
  logic        out_exception;
  logic [3:0]  out_tag;
  logic [2:0]  inflight;
  logic [2:0]  out_flags;
`ifdef FPU_RESULT_CLASSIFY_EN
  logic out_is_zero, out_is_denorm, out_is_inf_nan;
  assign out_flags = {out_is_zero, out_is_denorm, out_is_inf_nan};
`else
  assign out_flags = 3'b000;
`endif

  fpu_addsub_collector #(.LATENCY(LATENCY), .DEPTH(DEPTH), .TAG_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .issue_valid   (issue_valid),
    .issue_tag     (issue_tag),
    .issue_ready   (issue_ready),
    .add_result    (add_result),
    .add_exception (add_exception),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_exception (out_exception),
    .out_tag       (out_tag),
`ifdef FPU_RESULT_CLASSIFY_EN
    .out_is_zero   (out_is_zero),
    .out_is_denorm (out_is_denorm),
    .out_is_inf_nan(out_is_inf_nan),
`endif
    .inflight      (inflight)
  );

  // scoreboard state
  op_t  pend[$];
  op_t  exp_q[$];
  pop_t popped[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rise_cyc = -1;
  logic [3:0]  rise_tag;
  logic [63:0] rise_res;
  logic prev_ov = 1'b0;
  logic last_acc = 1'b0;
  int   acc_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2:0] exp_flags(input logic [63:0] r);
`ifdef FPU_RESULT_CLASSIFY_EN
    int unsigned e;
    logic [51:0] m;
    e = r[62:52];
    m = r[51:0];
    return {(e == 0) && (m == 0), (e == 0) && (m != 0), e == 2047};
`else
    return (r == r) ? 3'b000 : 3'b000;
`endif
  endfunction

  // driver: one clock cycle; checks the DUT against the model, then advances the model
  task automatic step(input logic en, input logic iv, input logic [3:0] tag,
                      input logic [63:0] res, input logic exc, input logic ordy);
    logic exp_ready, acc, pop, push;
    pop_t p;
    @(negedge clk);
    enable = en; issue_valid = iv; issue_tag = tag; out_ready = ordy;
    push = en && pend.size() > 0 && pend[0].rem == 1;
    if (pend.size() > 0 && pend[0].rem == 1) begin
      add_result = pend[0].res; add_exception = pend[0].exc;
    end else begin
      add_result = {$urandom, $urandom}; add_exception = 1'($urandom_range(0, 1));
    end
    #1;
    exp_ready = en && (pend.size() + exp_q.size() < DEPTH);
    check("issue_ready", 64'(issue_ready), 64'(exp_ready));
    check("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
    check("inflight", 64'(inflight), 64'(pend.size()));
    if (push) check("full_on_push", 64'(dut.fifo_full), 64'(0));
    if (exp_q.size() > 0) begin
      check("out_tag", 64'(out_tag), 64'(exp_q[0].tag));
      check("out_result", out_result, exp_q[0].res);
      check("out_exception", 64'(out_exception), 64'(exp_q[0].exc));
      check("out_flags", 64'(out_flags), 64'(exp_flags(exp_q[0].res)));
    end
    if (out_valid && !prev_ov) begin
      rise_cyc = cyc; rise_tag = out_tag; rise_res = out_result;
    end
    prev_ov  = out_valid;
    last_acc = iv & issue_ready;
    if (last_acc) acc_count++;
    if (out_valid && ordy) begin
      p.tag = out_tag; p.res = out_result; p.exc = out_exception; p.fl = out_flags;
      popped.push_back(p);
    end
    acc = iv && exp_ready;
    pop = exp_q.size() > 0 && ordy;
    if (pop) void'(exp_q.pop_front());
    if (en) begin
      foreach (pend[i]) pend[i].rem = pend[i].rem - 1;
      if (pend.size() > 0 && pend[0].rem == 0) exp_q.push_back(pend.pop_front());
    end
    if (acc) pend.push_back('{tag: tag, res: res, exc: exc, rem: LATENCY});
    cyc++;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'h0, 64'h0, 1'b0, ordy);
  endtask

  task automatic reset_checks(input string tagname);
    check({tagname, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tagname, "_inflight"}, 64'(inflight), 64'(0));
    check({tagname, "_issue_ready"}, 64'(issue_ready), 64'(0));
    check({tagname, "_out_result"}, out_result, 64'h0);
    check({tagname, "_out_tag"}, 64'(out_tag), 64'(0));
    check({tagname, "_out_exception"}, 64'(out_exception), 64'(0));
    check({tagname, "_out_flags"}, 64'(out_flags), 64'(0));
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 reset_checks("midrst");
    pend.delete(); exp_q.delete();
    enable = 1'b0; issue_valid = 1'b0; prev_ov = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [63:0] rand_result();
    case ($urandom_range(0, 5))
      0:       return 64'h0;
      1:       return 64'h0000_0000_0000_0001;
      2:       return 64'h7FF0_0000_0000_0000;
      3:       return 64'hFFF8_0000_0000_0001;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int c0, npop, next_tag, acc0;
    logic [63:0] r;
    logic ex;

    // reset state, with enable high to show readiness stays low
    rst_n = 1'b0; enable = 1'b1;
    repeat (3) @(negedge clk);
    #1 reset_checks("reset");
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // single op: out_valid three cycles after issue
    rise_cyc = -1; c0 = cyc;
    step(1'b1, 1'b1, 4'h3, 64'h3FF8_0000_0000_0000, 1'b0, 1'b1);
    idle(5, 1'b1);
    check("t2_latency", 64'(rise_cyc - c0), 64'(3));
    check("t2_tag", 64'(rise_tag), 64'h3);
    check("t2_result", rise_res, 64'h3FF8_0000_0000_0000);

    // enable stall
    rise_cyc = -1; npop = popped.size();
    step(1'b1, 1'b1, 4'h1, 64'h4000_0000_0000_0000, 1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0, 4'h0, 64'h0, 1'b0, 1'b1);
    check("t3_inflight_held", 64'(inflight), 64'(1));
    c0 = cyc;
    idle(6, 1'b1);
    check("t3_latency", 64'(rise_cyc - c0), 64'(2));
    check("t3_once", 64'(popped.size() - npop), 64'(1));

    // backpressure
    popped.delete(); next_tag = 0; acc0 = acc_count;
    repeat (10) begin
      step(1'b1, 1'b1, 4'(next_tag), rand_result(), 1'b0, 1'b0);
      if (last_acc) next_tag++;
    end
    check("t4_accepts", 64'(acc_count - acc0), 64'(DEPTH));
    idle(10, 1'b1);
    check("t4_pops", 64'(popped.size()), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++)
      if (i < popped.size()) check("t4_order", 64'(popped[i].tag), 64'(i));

    // exception between two normal ops
    popped.delete();
    step(1'b1, 1'b1, 4'h6, 64'h3FF0_0000_0000_0000, 1'b0, 1'b1);
    step(1'b1, 1'b1, 4'h7, 64'h0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 4'h8, 64'hC000_0000_0000_0000, 1'b0, 1'b1);
    idle(6, 1'b1);
    check("t5_count", 64'(popped.size()), 64'(3));
    if (popped.size() >= 3) begin
      check("t5_tag", 64'(popped[1].tag), 64'h7);
      check("t5_exc", 64'(popped[1].exc), 64'(1));
      check("t5_res", popped[1].res, 64'h0);
      check("t5_prev_exc", 64'(popped[0].exc), 64'(0));
      check("t5_prev_res", popped[0].res, 64'h3FF0_0000_0000_0000);
      check("t5_next_res", popped[2].res, 64'hC000_0000_0000_0000);
    end

`ifdef FPU_RESULT_CLASSIFY_EN
    popped.delete();
    step(1'b1, 1'b1, 4'h0, 64'h0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 4'h1, 64'h0000_0000_0000_0001, 1'b0, 1'b1);
    step(1'b1, 1'b1, 4'h2, 64'h7FF0_0000_0000_0000, 1'b0, 1'b1);
    idle(6, 1'b1);
    check("t6_count", 64'(popped.size()), 64'(3));
    if (popped.size() >= 3) begin
      check("t6_zero", 64'(popped[0].fl), 64'(3'b100));
      check("t6_denorm", 64'(popped[1].fl), 64'(3'b010));
      check("t6_infnan", 64'(popped[2].fl), 64'(3'b001));
    end
`endif

    // reset with two ops in flight; stale results must never appear
    popped.delete();
    step(1'b1, 1'b1, 4'h9, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'hA, 64'h5555_6666_7777_8888, 1'b0, 1'b0);
    mid_reset();
    idle(8, 1'b1);
    check("t1_no_stale", 64'(popped.size()), 64'(0));

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      if (i == 400) mid_reset();
      ex = ($urandom_range(0, 9) == 0);
      r  = ex ? 64'h0 : rand_result();
      step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 2) != 0),
           4'($urandom_range(0, 15)), r, ex, 1'($urandom_range(0, 3) != 0));
    end
    idle(12, 1'b1);
    check("drain_empty", 64'(out_valid), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
